pc_sequencer: RTL and testbench

Owns the fetch program counter and sequences its next value each cycle for the five-stage MIPS pipeline. Arbitrates among reset, exception, halt, branch/jump redirect (the `pc_bj`/`out` pair produced by the PC-source selector), fetch stall and sequential increment. Captures a redirect that arrives during a stall so it is never lost, and issues pipeline flush strobes to the IF/ID register. The PC is a word address: the sequential step is +1, matching the branch-target arithmetic.

---
 rtl/pc_sequencer_if.sv | 24 ++
 rtl/pc_sequencer.sv | 104 ++++++++++
 tb/tb_pc_sequencer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the fetch PC sequencer (slave) and the pipeline control (master).
interface pc_sequencer_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exc;
  logic        halt;
  logic        resume;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        flush_ifid;
  logic        pending;
  logic [31:0] redirect_count;

  modport master (
    output stall, redirect, redirect_pc, exc, halt, resume,
    input  pc, fetch_valid, flush_ifid, pending, redirect_count
  );

  modport slave (
    input  stall, redirect, redirect_pc, exc, halt, resume,
    output pc, fetch_valid, flush_ifid, pending, redirect_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer for the five-stage MIPS pipeline: exception/halt/redirect/stall arbitration.
// Define PCSEQ_DELAY_SLOT_EN to keep applied redirects from flushing IF/ID (architected delay slot).
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
  input  logic              clk,
  input  logic              rst,
  pc_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {RUN, PEND, HALT} state_t;

`ifdef PCSEQ_DELAY_SLOT_EN
  localparam logic REDIR_FLUSH = 1'b0;
`else
  localparam logic REDIR_FLUSH = 1'b1;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        flush;
  logic        apply_redir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      pend_pc_q <= 32'h0;
      cnt_q     <= 32'h0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    flush       = 1'b0;
    apply_redir = 1'b0;

    unique case (state_q)
      RUN: begin
        if (bus.exc) begin
          pc_d  = EXC_VECTOR;
          flush = 1'b1;
        end else if (bus.halt) begin
          state_d = HALT;
        end else if (bus.redirect && !bus.stall) begin
          pc_d        = bus.redirect_pc;
          apply_redir = 1'b1;
        end else if (bus.redirect) begin
          pend_pc_d = bus.redirect_pc;
          state_d   = PEND;
        end else if (!bus.stall) begin
          pc_d = pc_q + 32'd1;
        end
      end
      PEND: begin
        // New redirects are ignored here: the latched one is older in program order.
        if (bus.exc) begin
          pc_d      = EXC_VECTOR;
          flush     = 1'b1;
          pend_pc_d = 32'h0;
          state_d   = RUN;
        end else if (bus.halt) begin
          pend_pc_d = 32'h0;
          state_d   = HALT;
        end else if (!bus.stall) begin
          pc_d        = pend_pc_q;
          apply_redir = 1'b1;
          state_d     = RUN;
        end
      end
      HALT: begin
        // IF/ID holds no live fetch while halted, so the exception exit does not flush.
        if (bus.exc) begin
          pc_d    = EXC_VECTOR;
          state_d = RUN;
        end else if (bus.resume) begin
          pc_d    = pc_q + 32'd1;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    if (apply_redir) flush = REDIR_FLUSH;
    cnt_d = (apply_redir && (cnt_q != 32'hFFFF_FFFF)) ? cnt_q + 32'd1 : cnt_q;
  end

  assign bus.pc             = pc_q;
  assign bus.flush_ifid     = flush;
  assign bus.pending        = (state_q == PEND);
  assign bus.fetch_valid    = (state_q != HALT) && !bus.stall;
  assign bus.redirect_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, redirect, pending redirect, exception, halt, wrap, saturation.
module tb_pc_sequencer;

`ifdef PCSEQ_DELAY_SLOT_EN
  localparam logic [31:0] REDIR_FLUSH_EXP = 32'd0;
`else
  localparam logic [31:0] REDIR_FLUSH_EXP = 32'd1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(32'h0), .EXC_VECTOR(32'h20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic st, input logic rd, input logic [31:0] rpc,
                        input logic ex, input logic hl, input logic rs);
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.exc         = ex;
    bus.halt        = hl;
    bus.resume      = rs;
    #1;
  endtask

  initial begin
    set_in(0, 0, 32'h0, 0, 0, 0);
    #12;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_cnt", bus.redirect_count, 32'h0);
    chk("rst_pend", {31'd0, bus.pending}, 32'd0);
    chk("rst_flush", {31'd0, bus.flush_ifid}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("pc0", bus.pc, 32'h0);
    chk("fv0", {31'd0, bus.fetch_valid}, 32'd1);

    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("pc_inc", bus.pc, i);
      chk("flush_inc", {31'd0, bus.flush_ifid}, 32'd0);
    end
    chk("cnt_free", bus.redirect_count, 32'h0);

    // Plain redirect at pc=5
    set_in(0, 1, 32'h40, 0, 0, 0);
    chk("redir_flush", {31'd0, bus.flush_ifid}, REDIR_FLUSH_EXP);
    tick();
    set_in(0, 0, 32'h0, 0, 0, 0);
    chk("redir_pc", bus.pc, 32'h40);
    chk("redir_cnt", bus.redirect_count, 32'd1);
    chk("redir_flush_1cyc", {31'd0, bus.flush_ifid}, 32'd0);

    // Redirect under stall, second redirect ignored
    set_in(1, 1, 32'h80, 0, 0, 0);
    chk("stall_fv", {31'd0, bus.fetch_valid}, 32'd0);
    chk("stall_flush", {31'd0, bus.flush_ifid}, 32'd0);
    tick();
    chk("pend_pc1", bus.pc, 32'h40);
    chk("pend1", {31'd0, bus.pending}, 32'd1);
    set_in(1, 1, 32'h90, 0, 0, 0);
    tick();
    chk("pend_pc2", bus.pc, 32'h40);
    chk("pend2", {31'd0, bus.pending}, 32'd1);
    set_in(1, 0, 32'h0, 0, 0, 0);
    tick();
    chk("pend_pc3", bus.pc, 32'h40);
    chk("pend3", {31'd0, bus.pending}, 32'd1);
    set_in(0, 0, 32'h0, 0, 0, 0);
    chk("pend_flush", {31'd0, bus.flush_ifid}, REDIR_FLUSH_EXP);
    tick();
    chk("pend_apply_pc", bus.pc, 32'h80);
    chk("pend_clear", {31'd0, bus.pending}, 32'd0);
    chk("pend_cnt", bus.redirect_count, 32'd2);
    chk("pend_flush_1cyc", {31'd0, bus.flush_ifid}, 32'd0);
    tick();
    chk("pend_no90", bus.pc, 32'h81);

    // Exception while pending
    set_in(1, 1, 32'h200, 0, 0, 0);
    tick();
    chk("pend_b", {31'd0, bus.pending}, 32'd1);
    set_in(1, 0, 32'h0, 1, 0, 0);
    chk("exc_flush", {31'd0, bus.flush_ifid}, 32'd1);
    tick();
    set_in(0, 0, 32'h0, 0, 0, 0);
    chk("exc_pc", bus.pc, 32'h20);
    chk("exc_pend", {31'd0, bus.pending}, 32'd0);
    chk("exc_cnt", bus.redirect_count, 32'd2);

    // Halt beats redirect at pc=7
    set_in(0, 1, 32'h7, 0, 0, 0);
    tick();
    chk("to7", bus.pc, 32'h7);
    chk("to7_cnt", bus.redirect_count, 32'd3);
    set_in(0, 1, 32'h300, 0, 1, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(i[0], 1, 32'h300, 0, 0, 0);
      chk("halt_pc", bus.pc, 32'h7);
      chk("halt_fv", {31'd0, bus.fetch_valid}, 32'd0);
      chk("halt_flush", {31'd0, bus.flush_ifid}, 32'd0);
      tick();
    end
    chk("halt_cnt", bus.redirect_count, 32'd3);
    set_in(0, 0, 32'h0, 0, 0, 1);
    tick();
    set_in(0, 0, 32'h0, 0, 0, 0);
    chk("resume_pc", bus.pc, 32'h8);
    chk("resume_fv", {31'd0, bus.fetch_valid}, 32'd1);

    // Wrap and counter saturation
    force dut.cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cnt_q;
    set_in(0, 1, 32'hFFFF_FFFF, 0, 0, 0);
    tick();
    chk("wrap_pre", bus.pc, 32'hFFFF_FFFF);
    chk("sat_cnt1", bus.redirect_count, 32'hFFFF_FFFF);
    set_in(0, 0, 32'h0, 0, 0, 0);
    tick();
    chk("wrap_pc", bus.pc, 32'h0);
    set_in(0, 1, 32'h100, 0, 0, 0);
    tick();
    set_in(0, 0, 32'h0, 0, 0, 0);
    chk("sat_pc", bus.pc, 32'h100);
    chk("sat_cnt2", bus.redirect_count, 32'hFFFF_FFFF);

    // Reset mid-operation drops a pending redirect
    set_in(1, 1, 32'h500, 0, 0, 0);
    tick();
    chk("mid_pend", {31'd0, bus.pending}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_pc", bus.pc, 32'h0);
    chk("mid_rst_pend", {31'd0, bus.pending}, 32'd0);
    chk("mid_rst_cnt", bus.redirect_count, 32'h0);
    set_in(0, 0, 32'h0, 0, 0, 0);
    rst = 1'b0;
    tick();
    chk("mid_after_pc", bus.pc, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
